// File: rtl/gin_cfg_pkg.sv
// Shared types and sizing helpers for the GIN MCC ID scan-chain configuration controller.
// GIN_SCAN_VERIFY_EN adds the VERIFY state used by the read-back pass.
package gin_cfg_pkg;

    localparam int TAG_WIDTH_DEF = 4;
    localparam int NUM_MCC_DEF   = 12;
    localparam int CFG_WIDTH_DEF = 32;

`ifdef GIN_SCAN_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`endif

    function automatic int chain_len(input int tag_width, input int num_mcc);
        return tag_width * num_mcc;
    endfunction

    function automatic int num_words(input int chain, input int cfg_width);
        return (chain + cfg_width - 1) / cfg_width;
    endfunction

endpackage

// File: rtl/gin_id_scan_cfg_if.sv
// Valid/ready configuration-word bus feeding the ID scan controller.
interface gin_id_scan_cfg_if #(
    parameter int CFG_WIDTH = gin_cfg_pkg::CFG_WIDTH_DEF
);
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 cfg_valid;
    logic                 cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/gin_scan_shifter.sv
// Serialises a LEN-bit image onto scan_en/scan_in, bit 0 first; tc flags the last bit.
// A start pulse (re)launches a pass from bit 0, even on the terminal cycle of a running pass.
module gin_scan_shifter #(
    parameter int LEN = 48
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [LEN-1:0] data,
    output logic           scan_en,
    output logic           scan_in,
    output logic           tc
);
    localparam int CW = $clog2(LEN + 1);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_q, in_d;
    logic [IW-1:0] nxt_idx;

    assign tc      = active_q && (cnt_q == CW'(LEN - 1));
    assign nxt_idx = IW'(cnt_q + CW'(1));
    assign scan_en = active_q;
    assign scan_in = in_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        in_d     = in_q;
        if (abort) begin
            active_d = 1'b0;
            cnt_d    = '0;
            in_d     = 1'b0;
        end else if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            in_d     = data[0];
        end else if (active_q) begin
            if (tc) begin
                active_d = 1'b0;
                cnt_d    = '0;
                in_d     = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                in_d  = data[nxt_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            in_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            in_q     <= in_d;
        end
    end

endmodule

// File: rtl/gin_id_scan_cfg.sv
// GIN MCC ID scan-chain configuration controller: buffers the chain image, shifts it out, holds GIN off.
// Optional read-back pass enabled by defining GIN_SCAN_VERIFY_EN (adds verify_err).
module gin_id_scan_cfg
    import gin_cfg_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int NUM_MCC   = NUM_MCC_DEF,
    parameter int CFG_WIDTH = CFG_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    gin_id_scan_cfg_if.slave  cfg,
    input  logic              scan_out_id,
    output logic              scan_en_id,
    output logic              scan_in_id,
    output logic              gin_hold,
    output logic              busy,
    output logic              done
`ifdef GIN_SCAN_VERIFY_EN
    ,
    output logic              verify_err
`endif
);
    localparam int CHAIN_LEN = chain_len(TAG_WIDTH, NUM_MCC);
    localparam int NUM_WORDS = num_words(CHAIN_LEN, CFG_WIDTH);
    localparam int WCW       = $clog2(NUM_WORDS + 1);

    state_t                 state_q, state_d;
    logic [WCW-1:0]         word_cnt_q, word_cnt_d;
    logic [CHAIN_LEN-1:0]   shadow_q, shadow_d;
    logic                   done_q, done_d;
    logic                   beat;
    logic                   sh_start;
    logic                   sh_tc;

    assign cfg.cfg_ready = (state_q == ST_LOAD);
    assign beat          = cfg.cfg_valid && (state_q == ST_LOAD);
    assign busy          = (state_q != ST_IDLE);
    assign gin_hold      = busy;
    assign done          = done_q;

    // Each shadow bit belongs to exactly one word/bit position; padding bits of the last word are dropped.
    for (genvar gi = 0; gi < CHAIN_LEN; gi++) begin : g_shadow
        localparam int WORD_IDX = gi / CFG_WIDTH;
        localparam int BIT_IDX  = gi % CFG_WIDTH;
        assign shadow_d[gi] = (beat && (word_cnt_q == WCW'(WORD_IDX))) ? cfg.cfg_data[BIT_IDX]
                                                                      : shadow_q[gi];
    end

`ifdef GIN_SCAN_VERIFY_EN
    logic verify_err_q, verify_err_d;
    assign verify_err = verify_err_q;
`else
    logic unused_scan_out;
    assign unused_scan_out = scan_out_id;
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        sh_start   = 1'b0;
        done_d     = 1'b0;
`ifdef GIN_SCAN_VERIFY_EN
        verify_err_d = verify_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
`ifdef GIN_SCAN_VERIFY_EN
                    verify_err_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (word_cnt_q == WCW'(NUM_WORDS - 1)) begin
                        state_d    = ST_SHIFT;
                        word_cnt_d = '0;
                        sh_start   = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_tc) begin
`ifdef GIN_SCAN_VERIFY_EN
                    state_d  = ST_VERIFY;
                    sh_start = 1'b1;
`else
                    state_d  = ST_DONE;
`endif
                end
            end
`ifdef GIN_SCAN_VERIFY_EN
            ST_VERIFY: begin
                // The bit now leaving the tail was driven in as this same index one pass earlier.
                if (scan_en_id && (scan_out_id != scan_in_id))
                    verify_err_d = 1'b1;
                if (sh_tc)
                    state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            sh_start   = 1'b0;
            done_d     = 1'b0;
`ifdef GIN_SCAN_VERIFY_EN
            verify_err_d = verify_err_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            shadow_q   <= '0;
            done_q     <= 1'b0;
`ifdef GIN_SCAN_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            shadow_q   <= shadow_d;
            done_q     <= done_d;
`ifdef GIN_SCAN_VERIFY_EN
            verify_err_q <= verify_err_d;
`endif
        end
    end

    // shadow_d is passed so the first bit can be launched on the same edge as the final beat.
    gin_scan_shifter #(
        .LEN (CHAIN_LEN)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .start   (sh_start),
        .abort   (abort),
        .data    (shadow_d),
        .scan_en (scan_en_id),
        .scan_in (scan_in_id),
        .tc      (sh_tc)
    );

endmodule

// File: doc/gin_id_scan_cfg.md
Name: gin_id_scan_cfg

Overview:
- Configuration controller for the GIN multicast-controller ID scan chain.
- Accepts ID configuration words from the top-level config interface and buffers the full chain image in a shadow register.
- Drives scan_en_id/scan_in_id serially into the daisy-chained MCC ID flops.
- Holds GIN traffic off while the chain is being rewritten.

Parameters:
- TAG_WIDTH, 4, bits per MCC ID.
- NUM_MCC, 12, MCCs on the chain.
- CFG_WIDTH, 32, config word width.
- Derived localparams: CHAIN_LEN = NUM_MCC*TAG_WIDTH; NUM_WORDS = ceil(CHAIN_LEN/CFG_WIDTH).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a configuration pass; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE next cycle
- cfg_data  in  CFG_WIDTH  configuration word
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  controller accepts cfg_data
- scan_out_id  in  1  tail of MCC ID chain
- scan_en_id  out  1  shift enable to chain
- scan_in_id  out  1  serial bit to chain head
- gin_hold  out  1  high while busy; gates GIN enables upstream
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse on successful completion

Behaviour:
- Reset (reset=0): state IDLE, counters and shadow cleared. All outputs 0: cfg_ready, scan_en_id, scan_in_id, gin_hold, busy, done. Asynchronous, so scan_en_id drops immediately, including mid-shift. Chain contents are then undefined; software must reconfigure.
- States: IDLE, LOAD, SHIFT, DONE (plus VERIFY when the optional feature is compiled in).
- IDLE:
  - start=1 -> LOAD next cycle.
  - start is ignored in every other state.
- LOAD:
  - cfg_ready=1.
  - Each cfg_valid&cfg_ready beat j writes shadow[j*CFG_WIDTH +: CFG_WIDTH]. Bits beyond CHAIN_LEN in the last word are discarded.
  - word_cnt increments per beat. After beat NUM_WORDS-1 -> SHIFT; cfg_ready drops the cycle after the last beat.
  - Stalls (cfg_valid=0) are unlimited.
- SHIFT:
  - scan_en_id=1 for exactly CHAIN_LEN consecutive cycles.
  - Cycle k drives scan_in_id=shadow[k], k=0..CHAIN_LEN-1. shadow[0] therefore ends at the chain tail (nearest scan_out_id).
  - bit_cnt is $clog2(CHAIN_LEN+1) bits wide, no wrap. Terminal count CHAIN_LEN-1 -> DONE (or VERIFY).
  - scan_in_id is registered and changes only with scan_en_id high; it holds 0 otherwise.
- DONE: done=1 for one cycle, then IDLE. busy and gin_hold fall in the same cycle as done.
- busy = gin_hold = (state != IDLE).
- Latency with no stalls: start -> done = 1 + NUM_WORDS + CHAIN_LEN + 1 cycles (defaults: 1+2+48+1 = 52).
- abort:
  - Has priority over every transition.
  - In any non-IDLE state -> IDLE next cycle. scan_en_id=0 and cfg_ready=0 from that edge, no done pulse, counters cleared.
  - abort and start together in IDLE: stay in IDLE.
- Chain state after an abort during SHIFT is undefined; no recovery is attempted.

Optional Feature:
- Macro: GIN_SCAN_VERIFY_EN.
- Defined:
  - Adds output verify_err (1 bit, reset 0) and state VERIFY between SHIFT and DONE.
  - VERIFY shifts shadow[k] again for CHAIN_LEN cycles with scan_en_id=1. In the same cycle k it compares scan_out_id against shadow[k]; the chain content is preserved after the pass.
  - Any mismatch sets a sticky verify_err, cleared on the next start.
  - At the end of VERIFY -> DONE. done pulses regardless; verify_err is valid when done=1.
  - Latency adds CHAIN_LEN cycles.
- Undefined: no VERIFY state, no verify_err port, and scan_out_id is unused.

Decomposition:
- Package gin_cfg_pkg: state enum, TAG_WIDTH/NUM_MCC/CFG_WIDTH defaults, CHAIN_LEN/NUM_WORDS functions.
- Sub-module gin_scan_shifter: the bit counter plus the scan_en_id/scan_in_id drive, with load/start/abort and a terminal-count output. It is instantiated once and reused for the VERIFY pass.

Test Plan:
- Defaults; start, words 0x76543210 then 0xBA98 (upper bits 0xFFFF garbage) -> 48 scan_en cycles, scan_in sequence = LSB-first of 0xBA9876543210. A modelled 12x4 chain ends with MCC IDs 0..B. done at cycle 52; gin_hold high for cycles 1..51.
- cfg_valid held low 5 cycles between beats -> cfg_ready stays high, shift starts only after beat 2, done at cycle 57.
- abort asserted at shift cycle 20 -> scan_en low next cycle, busy low, no done. A subsequent start performs a full 48-bit pass.
- reset low at shift cycle 10 -> all outputs 0 immediately; after release, start alone (no cfg beats) stays in LOAD with cfg_ready=1.
- start pulsed during SHIFT -> ignored; exactly one done pulse.
- GIN_SCAN_VERIFY_EN: correct chain model -> done at cycle 100, verify_err=0. Chain model with a stuck-at-0 bit -> verify_err=1 at done.
